cabac_intra_luma_nbr: RTL and testbench
=======================================

# cabac_intra_luma_nbr

Neighbour-mode fetch stage that sits directly upstream of the intra-luma syntax-element preparation logic in the CABAC front end. It accepts coded CUs of one 64x64 LCU in z-order and splits each intra CU into its luma PUs. For every PU it emits the current, left and top luma modes over a valid/ready handshake. It keeps per-LCU left-column and top-row mode memories at 4x4 granularity and applies the HEVC availability and CTB-boundary substitution rules. Substituted neighbours are reported as DC (mode 1).

## Interface
Parameters: none.
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `lcu_start_i`  in  1  single-cycle pulse before the first CU of an LCU
- `lcu_left_avail_i`  in  1  qualifies `lcu_start_i`; left LCU exists and is in the same slice/tile
- `cu_valid_i`  in  1  CU descriptor valid
- `cu_ready_o`  out  1  CU accepted when `cu_valid_i & cu_ready_o`
- `cu_x_i`, `cu_y_i`  in  4 each  CU origin in 4x4 units within the LCU, aligned to the CU size
- `cu_size_i`  in  2  0=8x8, 1=16x16, 2=32x32, 3=64x64
- `cu_intra_i`  in  1  CU is intra
- `cu_nxn_i`  in  1  NxN partition; legal only when `cu_size_i`=0
- `cu_mode_i`  in  24  PU k luma mode at [6k+5:6k]; only PU0 is used for 2Nx2N
- `se_valid_o`  out  1  PU record valid
- `se_ready_i`  in  1  downstream accepts the record
- `cur_mode_o`, `left_mode_o`, `top_mode_o`  out  6 each  PU modes for the downstream mode-prediction logic
- `pu_idx_o`  out  2  PU index within the CU
- `pu_last_o`  out  1  last PU of the CU

## Operation
- Storage: `left_arr[0..15]` is indexed by 4x4 row. `top_arr[0..15]` is indexed by 4x4 column. Each entry is 6 bits. Z-order guarantees that the last write to a row or column is the direct neighbour.
- FSM states are IDLE, LOAD, WAIT and INTER.
- IDLE:
  - `cu_ready_o = !lcu_start_i`.
  - `lcu_start_i` has priority over a CU in the same cycle. When `lcu_start_i` is high and `lcu_left_avail_i`=0, all `left_arr` entries are set to 1. When `lcu_left_avail_i`=1, `left_arr` is kept, because it holds the previous LCU's right column.
  - On CU accept: latch the descriptor, set k=0, and go to INTER if `!cu_intra_i`, otherwise to LOAD.
- PU geometry:
  - 2Nx2N: one PU at (x,y) with width w = 2<<size, in 4x4 units.
  - NxN: four PUs, w=1. PU k is at (x+k[0], y+k[1]).
  - Footprint: entry i is covered when px ≤ i < px+w. The comparison is done at 5 bits; no wrap-around occurs for aligned input.
- LOAD:
  - Register `cur_mode_o` = mode k.
  - Register `left_mode_o = left_arr[py]`.
  - Register `top_mode_o` = (py==0) ? 1 : `top_arr[px]`. A top neighbour outside the CTB is always replaced by DC.
  - Register `pu_idx_o` = k and `pu_last_o` = (2Nx2N or k==3).
  - Set `se_valid_o` and go to WAIT.
- WAIT:
  - Outputs are held stable while `se_ready_i`=0.
  - On handshake, write cur_mode into `top_arr` over the footprint columns and into `left_arr` over the footprint rows, all in one cycle.
  - Clear `se_valid_o`. If `pu_last_o`, go to IDLE; otherwise increment k and go to LOAD. The next PU then sees the updated arrays, for example NxN PU1 takes PU0's mode as its left neighbour.
- INTER: write 1 (DC) over the CU footprint in both arrays, emit nothing, and go to IDLE.
- Modes are passed through unchecked; values above 34 are not clipped. Misaligned or out-of-LCU CU descriptors give undefined results.

## Timing
- Reset values:
  - state IDLE, `se_valid_o`=0, `cu_ready_o`=1.
  - `cur_mode_o`, `left_mode_o`, `top_mode_o`, `pu_idx_o`, `pu_last_o` all 0.
  - every `left_arr` and `top_arr` entry = 1.
- Reset asserted at any time immediately clears `se_valid_o` and the FSM state. Any in-flight CU is discarded.
- CU accepted in cycle A: `se_valid_o` is high from cycle A+2.
- PU handshake in cycle H:
  - the arrays are updated at the end of H;
  - the next PU of the same CU is valid from H+2;
  - after the last PU, `cu_ready_o` is high in H+1.
- Throughput: 2 cycles per PU plus 1 cycle per CU in IDLE. An inter CU occupies 2 cycles in total (accept cycle plus INTER).
- `cu_ready_o` is 0 in LOAD, WAIT and INTER.
- `se_valid_o` never falls without a handshake, except on reset.

## Test plan
- Reset, then lcu_start with left_avail=0, then intra 64x64 at (0,0) with mode 26: one record cur=26 L=1 T=1 last=1. Next, lcu_start with left_avail=1, then intra 8x8 at (0,0) with mode 10: L=26, T=1.
- Fresh LCU with left_avail=0, NxN 8x8 at (0,0) with modes 2,3,4,5: records are (2,L1,T1), (3,L2,T1), (4,L1,T2), (5,L4,T3), with pu_last only on the fourth.
- Intra 8x8 at (0,0) with mode 18, then inter 8x8 at (2,0), then intra 8x8 at (0,2) with mode 7, then intra 8x8 at (2,2) with mode 9. The (0,2) record has T=18. The (2,2) record has L=7 and T=1, since the inter CU above is reported as DC.
- Hold `se_ready_i`=0 for 5 cycles during WAIT: all outputs are stable and `cu_ready_o`=0. Release: exactly one handshake occurs, and the next PU record appears 2 cycles later.
- Drive `lcu_start_i` and `cu_valid_i` in the same IDLE cycle: `cu_ready_o`=0 and the left-array init is applied. The CU is accepted the next cycle and sees L=1 at x=0.
- Assert `rst` mid-WAIT: `se_valid_o` goes to 0 asynchronously. After release, an intra 16x16 CU at (4,4) with mode 3 yields L=1 and T=1.

Source files
------------

// File: rtl/cabac_intra_luma_nbr.sv
// cabac_intra_luma_nbr: splits CUs into luma PUs and emits current/left/top modes from per-LCU neighbour memories
module cabac_intra_luma_nbr (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcu_start_i,
  input  logic        lcu_left_avail_i,
  input  logic        cu_valid_i,
  output logic        cu_ready_o,
  input  logic [3:0]  cu_x_i,
  input  logic [3:0]  cu_y_i,
  input  logic [1:0]  cu_size_i,
  input  logic        cu_intra_i,
  input  logic        cu_nxn_i,
  input  logic [23:0] cu_mode_i,
  output logic        se_valid_o,
  input  logic        se_ready_i,
  output logic [5:0]  cur_mode_o,
  output logic [5:0]  left_mode_o,
  output logic [5:0]  top_mode_o,
  output logic [1:0]  pu_idx_o,
  output logic        pu_last_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, INTER} state_t;
  state_t      st;
  logic [1:0]  k;
  logic [3:0]  x, y;
  logic [1:0]  sz;
  logic        nxn;
  logic [23:0] modes;
  logic [5:0]  left_arr [16];
  logic [5:0]  top_arr [16];
  logic [5:0]  mk;
  logic [4:0]  px, py, w;
  assign cu_ready_o = (st == IDLE) && !lcu_start_i;
  // current PU mode and footprint; an inter CU is latched with nxn=0 so this is the whole CU
  always_comb begin
    mk = k == 2'd0 ? modes[5:0] : k == 2'd1 ? modes[11:6] : k == 2'd2 ? modes[17:12] : modes[23:18];
    px = {1'b0, x} + {4'b0, nxn & k[0]};
    py = {1'b0, y} + {4'b0, nxn & k[1]};
    w  = nxn ? 5'd1 : 5'd2 << sz;
  end
  // control FSM with registered PU record and neighbour-memory updates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= IDLE;
      se_valid_o  <= 1'b0;
      cur_mode_o  <= '0;
      left_mode_o <= '0;
      top_mode_o  <= '0;
      pu_idx_o    <= '0;
      pu_last_o   <= 1'b0;
      k           <= '0;
      x           <= '0;
      y           <= '0;
      sz          <= '0;
      nxn         <= 1'b0;
      modes       <= '0;
      for (int i = 0; i < 16; i++) begin
        left_arr[i] <= 6'd1;
        top_arr[i]  <= 6'd1;
      end
    end else begin
      case (st)
        IDLE: begin
          if (lcu_start_i) begin
            if (!lcu_left_avail_i)
              for (int i = 0; i < 16; i++) left_arr[i] <= 6'd1;
          end else if (cu_valid_i) begin
            x     <= cu_x_i;
            y     <= cu_y_i;
            sz    <= cu_size_i;
            nxn   <= cu_nxn_i & cu_intra_i;
            modes <= cu_mode_i;
            k     <= '0;
            st    <= cu_intra_i ? LOAD : INTER;
          end
        end
        LOAD: begin
          cur_mode_o  <= mk;
          left_mode_o <= left_arr[py[3:0]];
          top_mode_o  <= py == 5'd0 ? 6'd1 : top_arr[px[3:0]];
          pu_idx_o    <= k;
          pu_last_o   <= !nxn || k == 2'd3;
          se_valid_o  <= 1'b1;
          st          <= WAIT;
        end
        WAIT: begin
          if (se_ready_i) begin
            for (int i = 0; i < 16; i++) begin
              if (5'(i) >= px && 5'(i) < px + w) top_arr[i] <= cur_mode_o;
              if (5'(i) >= py && 5'(i) < py + w) left_arr[i] <= cur_mode_o;
            end
            se_valid_o <= 1'b0;
            k          <= k + 2'd1;
            st         <= pu_last_o ? IDLE : LOAD;
          end
        end
        default: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) >= px && 5'(i) < px + w) top_arr[i] <= 6'd1;
            if (5'(i) >= py && 5'(i) < py + w) left_arr[i] <= 6'd1;
          end
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cabac_intra_luma_nbr.sv
// tb_cabac_intra_luma_nbr: directed and random quadtree LCUs checked against a neighbour-array model
module tb_cabac_intra_luma_nbr;
  logic        clk = 0, rst = 1;
  logic        lcu_start_i = 0, lcu_left_avail_i = 0, cu_valid_i = 0;
  logic        cu_intra_i = 0, cu_nxn_i = 0, se_ready_i = 0;
  logic [3:0]  cu_x_i = 0, cu_y_i = 0;
  logic [1:0]  cu_size_i = 0;
  logic [23:0] cu_mode_i = 0;
  logic        cu_ready_o, se_valid_o, pu_last_o;
  logic [5:0]  cur_mode_o, left_mode_o, top_mode_o;
  logic [1:0]  pu_idx_o;
  int n_chk = 0, n_pass = 0;
  int lm [16];
  int tm [16];
  cabac_intra_luma_nbr dut (
    .clk(clk), .rst(rst), .lcu_start_i(lcu_start_i), .lcu_left_avail_i(lcu_left_avail_i),
    .cu_valid_i(cu_valid_i), .cu_ready_o(cu_ready_o), .cu_x_i(cu_x_i), .cu_y_i(cu_y_i),
    .cu_size_i(cu_size_i), .cu_intra_i(cu_intra_i), .cu_nxn_i(cu_nxn_i), .cu_mode_i(cu_mode_i),
    .se_valid_o(se_valid_o), .se_ready_i(se_ready_i), .cur_mode_o(cur_mode_o),
    .left_mode_o(left_mode_o), .top_mode_o(top_mode_o), .pu_idx_o(pu_idx_o), .pu_last_o(pu_last_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset;
    for (int i = 0; i < 16; i++) begin
      lm[i] = 1;
      tm[i] = 1;
    end
  endtask
  task automatic lcu(input bit avail);
    lcu_start_i = 1;
    lcu_left_avail_i = avail;
    #1;
    check("lcu_ready", cu_ready_o, 0);
    tick;
    lcu_start_i = 0;
    if (!avail) for (int i = 0; i < 16; i++) lm[i] = 1;
  endtask
  task automatic do_cu(input int x, input int y, input int sz, input bit intra, input bit nxn,
                       input logic [23:0] modes, input int smin, input int smax);
    int lat, px, py, w, cur, el, et, last, st;
    cu_x_i = 4'(x); cu_y_i = 4'(y); cu_size_i = 2'(sz);
    cu_intra_i = intra; cu_nxn_i = nxn; cu_mode_i = modes; cu_valid_i = 1;
    #1;
    check("cu_ready_idle", cu_ready_o, 1);
    tick;
    cu_valid_i = 0;
    w = nxn ? 1 : 2 << sz;
    if (!intra) begin
      check("inter_busy", cu_ready_o, 0);
      check("inter_no_rec", se_valid_o, 0);
      tick;
      for (int i = 0; i < w; i++) begin
        tm[x + i] = 1;
        lm[y + i] = 1;
      end
      return;
    end
    for (int p = 0; p < (nxn ? 4 : 1); p++) begin
      px = x + (nxn ? p % 2 : 0);
      py = y + (nxn ? p / 2 : 0);
      cur = int'((modes >> (6 * p)) & 24'h3f);
      el = lm[py];
      et = py == 0 ? 1 : tm[px];
      last = (!nxn || p == 3) ? 1 : 0;
      lat = 1;
      while (!se_valid_o && lat < 8) begin
        tick;
        lat++;
      end
      check("pu_latency", lat, 2);
      if (!se_valid_o) return;
      st = $urandom_range(smax, smin);
      for (int s = 0; s <= st; s++) begin
        check("cur", cur_mode_o, cur);
        check("left", left_mode_o, el);
        check("top", top_mode_o, et);
        check("idx", pu_idx_o, p);
        check("last", pu_last_o, last);
        check("valid_hold", se_valid_o, 1);
        check("busy", cu_ready_o, 0);
        if (s < st) tick;
      end
      se_ready_i = 1;
      tick;
      se_ready_i = 0;
      check("one_handshake", se_valid_o, 0);
      for (int i = 0; i < w; i++) begin
        tm[px + i] = cur;
        lm[py + i] = cur;
      end
    end
    check("ready_after_last", cu_ready_o, 1);
  endtask
  task automatic rnd_cu(input int x, input int y, input int sz);
    bit intra, nxn;
    intra = $urandom_range(0, 3) != 0;
    nxn = intra && sz == 0 && $urandom_range(0, 1) == 1;
    do_cu(x, y, sz, intra, nxn, 24'($urandom), 0, 2);
  endtask
  initial begin
    int ax, ay, bx, by;
    model_reset;
    #1;
    check("rst_valid", se_valid_o, 0);
    check("rst_ready", cu_ready_o, 1);
    check("rst_cur", cur_mode_o, 0);
    check("rst_left", left_mode_o, 0);
    check("rst_top", top_mode_o, 0);
    check("rst_idx", pu_idx_o, 0);
    check("rst_last", pu_last_o, 0);
    tick;
    tick;
    rst = 0;
    lcu(0);
    do_cu(0, 0, 3, 1, 0, 24'd26, 0, 0);
    lcu(1);
    do_cu(0, 0, 0, 1, 0, 24'd10, 0, 0);
    lcu(0);
    do_cu(0, 0, 0, 1, 1, {6'd5, 6'd4, 6'd3, 6'd2}, 0, 0);
    lcu(0);
    do_cu(0, 0, 0, 1, 0, 24'd18, 0, 0);
    do_cu(2, 0, 0, 0, 0, 24'd0, 0, 0);
    do_cu(0, 2, 0, 1, 0, 24'd7, 0, 0);
    do_cu(2, 2, 0, 1, 0, 24'd9, 0, 0);
    do_cu(4, 0, 0, 1, 1, {6'd40, 6'd33, 6'd20, 6'd11}, 5, 5);
    cu_x_i = 0; cu_y_i = 0; cu_size_i = 0; cu_intra_i = 1; cu_nxn_i = 0; cu_mode_i = 24'd33;
    lcu_start_i = 1; lcu_left_avail_i = 0; cu_valid_i = 1;
    #1;
    check("start_blocks_cu", cu_ready_o, 0);
    tick;
    lcu_start_i = 0;
    for (int i = 0; i < 16; i++) lm[i] = 1;
    do_cu(0, 0, 0, 1, 0, 24'd33, 0, 0);
    cu_x_i = 8; cu_y_i = 0; cu_size_i = 1; cu_intra_i = 1; cu_nxn_i = 0; cu_mode_i = 24'd12;
    cu_valid_i = 1;
    tick;
    cu_valid_i = 0;
    tick;
    check("pre_rst_valid", se_valid_o, 1);
    rst = 1;
    #1;
    check("async_rst_valid", se_valid_o, 0);
    tick;
    rst = 0;
    model_reset;
    check("post_rst_ready", cu_ready_o, 1);
    do_cu(4, 4, 1, 1, 0, 24'd3, 0, 0);
    for (int n = 0; n < 4; n++) begin
      lcu($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) rnd_cu(0, 0, 3);
      else for (int a = 0; a < 4; a++) begin
        ax = (a % 2) * 8;
        ay = (a / 2) * 8;
        if ($urandom_range(0, 2) == 0) rnd_cu(ax, ay, 2);
        else for (int b = 0; b < 4; b++) begin
          bx = ax + (b % 2) * 4;
          by = ay + (b / 2) * 4;
          if ($urandom_range(0, 1) == 1) rnd_cu(bx, by, 1);
          else for (int c = 0; c < 4; c++) rnd_cu(bx + (c % 2) * 2, by + (c / 2) * 2, 0);
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
